// File: rtl/dma_priority_ctrl.sv
// dma_priority_ctrl: four-channel DMA request arbiter with HOLD handshake.
// Selects fixed or rotating priority, grants one channel per bus ownership,
// tracks per-channel terminal count, and drives registered DACK/HRQ.
module dma_priority_ctrl #(
    parameter int DACK_ACT_HIGH = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MCLR,
    input  logic [3:0] DREQ,
    input  logic [3:0] MASK,
    input  logic [3:0] BLK,
    input  logic       ROT_PRI,
    input  logic       CTRL_DIS,
    input  logic       HLDA,
    input  logic       XFER_DONE,
    input  logic       EOP_IN,
    input  logic       STAT_RD,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic [1:0] ACT_CH,
    output logic       ACT_VLD,
    output logic [7:0] STATUS
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD_REQ = 2'd1,
        S_ACTIVE   = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] DACK_IDLE = (DACK_ACT_HIGH != 0) ? 4'b0000 : 4'b1111;

    // state and bookkeeping registers
    state_t     r_state;
    logic [1:0] r_ch;
    logic [1:0] r_ptr;
    logic [3:0] r_tc;
    logic [3:0] r_dreq;

    // registered outputs
    logic       r_hrq;
    logic [3:0] r_dack;
    logic       r_act_vld;

    // combinational next values
    state_t     w_next;
    logic [1:0] w_next_ch;
    logic [1:0] w_next_ptr;
    logic [3:0] w_next_tc;
    logic       w_set_tc;
    logic [3:0] w_elig;
    logic [1:0] w_base;
    logic [1:0] w_win;
    logic [1:0] w_idx;
    logic       w_found;
    logic [3:0] w_grant_oh;
    logic [3:0] w_cur_oh;

    function automatic logic [3:0] f_onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign w_elig   = DREQ & ~MASK;
    // fixed priority is simply rotating priority with the pointer pinned at 0
    assign w_base   = ROT_PRI ? r_ptr : 2'd0;
    assign w_cur_oh = f_onehot(r_ch);

    // scan upward from the pointer, wrapping, for the first eligible channel
    always_comb begin
        w_win   = w_base;
        w_found = 1'b0;
        w_idx   = w_base;
        for (int i = 0; i < 4; i++) begin
            w_idx = w_base + 2'(i);
            if (!w_found && w_elig[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // next-state, grant latch, pointer and terminal-count decisions
    always_comb begin
        w_next     = r_state;
        w_next_ch  = r_ch;
        w_next_ptr = ROT_PRI ? r_ptr : 2'd0;
        w_set_tc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((|w_elig) && !CTRL_DIS)
                    w_next = S_HOLD_REQ;
            end
            S_HOLD_REQ: begin
                if (HLDA) begin
                    if (|w_elig) begin
                        w_next    = S_ACTIVE;
                        w_next_ch = w_win;
                    end else begin
                        // request withdrawn while waiting for the bus
                        w_next = S_RELEASE;
                    end
                end
            end
            S_ACTIVE: begin
                if (!HLDA) begin
                    // CPU took the bus back: abort without TC or pointer update
                    w_next = S_IDLE;
                end else if (EOP_IN) begin
                    w_next   = S_RELEASE;
                    w_set_tc = 1'b1;
                    if (ROT_PRI)
                        w_next_ptr = r_ch + 2'd1;
                end else if (XFER_DONE && !BLK[r_ch]) begin
                    w_next = S_RELEASE;
                    if (ROT_PRI)
                        w_next_ptr = r_ch + 2'd1;
                end
            end
            S_RELEASE: begin
                if (!HLDA)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // a TC set in the same cycle as a status read survives the clear
    assign w_next_tc  = (STAT_RD ? 4'b0000 : r_tc) | (w_set_tc ? w_cur_oh : 4'b0000);
    assign w_grant_oh = f_onehot(w_next_ch);

    // FSM state, granted channel, priority pointer and TC flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_ch    <= 2'd0;
            r_ptr   <= 2'd0;
            r_tc    <= 4'b0000;
        end else if (MCLR) begin
            r_state <= S_IDLE;
            r_ch    <= 2'd0;
            r_ptr   <= 2'd0;
            r_tc    <= 4'b0000;
        end else begin
            r_state <= w_next;
            r_ch    <= w_next_ch;
            r_ptr   <= w_next_ptr;
            r_tc    <= w_next_tc;
        end
    end

    // outputs are decoded from the next state so they line up with it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hrq     <= 1'b0;
            r_dack    <= DACK_IDLE;
            r_act_vld <= 1'b0;
        end else if (MCLR) begin
            r_hrq     <= 1'b0;
            r_dack    <= DACK_IDLE;
            r_act_vld <= 1'b0;
        end else begin
            r_hrq     <= (w_next == S_HOLD_REQ) || (w_next == S_ACTIVE);
            r_act_vld <= (w_next == S_ACTIVE);
            if (w_next == S_ACTIVE)
                r_dack <= (DACK_ACT_HIGH != 0) ? w_grant_oh : ~w_grant_oh;
            else
                r_dack <= DACK_IDLE;
        end
    end

    // request snapshot for the status register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_dreq <= 4'b0000;
        else if (MCLR)
            r_dreq <= 4'b0000;
        else
            r_dreq <= DREQ;
    end

    assign HRQ     = r_hrq;
    assign DACK    = r_dack;
    assign ACT_CH  = r_ch;
    assign ACT_VLD = r_act_vld;
    assign STATUS  = {r_dreq, r_tc};

endmodule

// File: tb/tb_dma_priority_ctrl.sv
// Bench for dma_priority_ctrl: directed scenarios followed by random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_dma_priority_ctrl;

    logic       CLK = 1'b0;
    logic       RESET, MCLR;
    logic [3:0] DREQ, MASK, BLK;
    logic       ROT_PRI, CTRL_DIS, HLDA, XFER_DONE, EOP_IN, STAT_RD;
    logic       HRQ, ACT_VLD;
    logic [3:0] DACK;
    logic [1:0] ACT_CH;
    logic [7:0] STATUS;

    int total = 0;
    int bad   = 0;

    // behavioural model: 0 idle, 1 waiting for bus, 2 transferring, 3 giving bus back
    int         m_st;
    logic [1:0] m_ch, m_ptr;
    logic [3:0] m_tc, m_dq;

    dma_priority_ctrl #(.DACK_ACT_HIGH(0)) dut (
        .CLK(CLK), .RESET(RESET), .MCLR(MCLR), .DREQ(DREQ), .MASK(MASK), .BLK(BLK),
        .ROT_PRI(ROT_PRI), .CTRL_DIS(CTRL_DIS), .HLDA(HLDA), .XFER_DONE(XFER_DONE),
        .EOP_IN(EOP_IN), .STAT_RD(STAT_RD), .HRQ(HRQ), .DACK(DACK), .ACT_CH(ACT_CH),
        .ACT_VLD(ACT_VLD), .STATUS(STATUS)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] pick(input logic [3:0] e, input logic [1:0] p);
        for (int k = 0; k < 4; k++)
            if (e[(int'(p) + k) % 4]) return 2'((int'(p) + k) % 4);
        return p;
    endfunction

    task automatic model_reset();
        m_st = 0; m_ch = 2'd0; m_ptr = 2'd0; m_tc = 4'd0; m_dq = 4'd0;
    endtask

    task automatic model_clk();
        logic [3:0] e, tc;
        logic [1:0] p, ch;
        int st;
        if (RESET || MCLR) begin
            model_reset();
            return;
        end
        e  = DREQ & ~MASK;
        p  = ROT_PRI ? m_ptr : 2'd0;
        tc = STAT_RD ? 4'd0 : m_tc;
        st = m_st;
        ch = m_ch;
        case (m_st)
            0: if (e != 0 && !CTRL_DIS) st = 1;
            1: if (HLDA) begin
                   if (e != 0) begin st = 2; ch = pick(e, p); end
                   else st = 3;
               end
            2: if (!HLDA) st = 0;
               else if (EOP_IN) begin
                   st = 3;
                   tc[m_ch] = 1'b1;
                   if (ROT_PRI) p = 2'((int'(m_ch) + 1) % 4);
               end else if (XFER_DONE && !BLK[m_ch]) begin
                   st = 3;
                   if (ROT_PRI) p = 2'((int'(m_ch) + 1) % 4);
               end
            default: if (!HLDA) st = 0;
        endcase
        m_st = st; m_ch = ch; m_ptr = p; m_tc = tc; m_dq = DREQ;
    endtask

    function automatic logic [15:0] exp_vec();
        logic [3:0] dk;
        dk = (m_st == 2) ? ~(4'b0001 << m_ch) : 4'b1111;
        return {(m_st == 1 || m_st == 2), dk, m_ch, (m_st == 2), m_dq, m_tc};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {HRQ, DACK, ACT_CH, ACT_VLD, STATUS};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_clk();
        @(negedge CLK);
        chk(tag, obs_vec(), exp_vec());
    endtask

    initial begin
        RESET = 1'b1; MCLR = 1'b0; DREQ = 4'd0; MASK = 4'd0; BLK = 4'd0;
        ROT_PRI = 1'b0; CTRL_DIS = 1'b0; HLDA = 1'b0; XFER_DONE = 1'b0;
        EOP_IN = 1'b0; STAT_RD = 1'b0;
        model_reset();
        @(negedge CLK); @(negedge CLK);
        chk("reset_hrq", 16'(HRQ), 16'h0);
        chk("reset_dack", 16'(DACK), 16'hF);
        chk("reset_act", 16'({ACT_CH, ACT_VLD}), 16'h0);
        chk("reset_status", 16'(STATUS), 16'h0);
        RESET = 1'b0;

        // fixed priority picks ch1 out of 1010
        DREQ = 4'b1010;
        tick("fix_hreq");
        chk("fix_hrq", 16'(HRQ), 16'h1);
        HLDA = 1'b1;
        tick("fix_act");
        chk("fix_dack", 16'(DACK), 16'hD);
        chk("fix_ch", 16'(ACT_CH), 16'h1);
        XFER_DONE = 1'b1;
        tick("fix_rel");
        XFER_DONE = 1'b0; HLDA = 1'b0; DREQ = 4'd0;
        tick("fix_idle");

        // rotating priority with all channels requesting
        ROT_PRI = 1'b1; DREQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick("rot_hreq");
            HLDA = 1'b1;
            tick("rot_act");
            chk("rot_ch", 16'(ACT_CH), 16'(k % 4));
            XFER_DONE = 1'b1;
            tick("rot_rel");
            XFER_DONE = 1'b0; HLDA = 1'b0;
            tick("rot_idle");
        end
        ROT_PRI = 1'b0; DREQ = 4'd0;
        tick("rot_quiet");

        // block mode on ch2: DACK held across transfers until EOP
        BLK = 4'b0100; DREQ = 4'b0100;
        tick("blk_hreq");
        HLDA = 1'b1;
        tick("blk_act");
        for (int k = 0; k < 5; k++) begin
            XFER_DONE = 1'b1;
            tick("blk_xfer");
            chk("blk_dack", 16'({DACK, ACT_VLD}), 16'h17);
            XFER_DONE = 1'b0;
            tick("blk_gap");
        end
        EOP_IN = 1'b1;
        tick("blk_eop");
        chk("blk_hrq_drop", 16'(HRQ), 16'h0);
        chk("blk_tc", 16'(STATUS[3:0]), 16'h4);
        EOP_IN = 1'b0; HLDA = 1'b0; DREQ = 4'd0; BLK = 4'd0;
        tick("blk_idle");
        STAT_RD = 1'b1;
        tick("blk_statrd");
        chk("blk_tc_clr", 16'(STATUS[3:0]), 16'h0);
        STAT_RD = 1'b0;

        // request withdrawn before the bus was granted
        DREQ = 4'b0001;
        tick("wd_hreq");
        DREQ = 4'd0; HLDA = 1'b1;
        tick("wd_rel");
        chk("wd_nodack", 16'({HRQ, DACK, ACT_VLD}), 16'h1E);
        HLDA = 1'b0;
        tick("wd_idle");

        // HLDA drop in ACTIVE overrides a simultaneous EOP
        DREQ = 4'b0010;
        tick("hd_hreq");
        HLDA = 1'b1;
        tick("hd_act");
        HLDA = 1'b0; EOP_IN = 1'b1;
        tick("hd_idle");
        chk("hd_out", 16'({HRQ, DACK, STATUS[3:0]}), 16'h0F0);
        EOP_IN = 1'b0; DREQ = 4'd0;
        tick("hd_quiet");

        // EOP + XFER_DONE + STAT_RD together: TC set wins
        DREQ = 4'b1000;
        tick("ex_hreq");
        HLDA = 1'b1;
        tick("ex_act");
        EOP_IN = 1'b1; XFER_DONE = 1'b1; STAT_RD = 1'b1;
        tick("ex_rel");
        chk("ex_tc", 16'(STATUS[3:0]), 16'h8);
        EOP_IN = 1'b0; XFER_DONE = 1'b0; STAT_RD = 1'b0; HLDA = 1'b0;
        tick("ex_idle");

        // asynchronous reset mid-transfer
        DREQ = 4'b0001;
        tick("ar_hreq");
        HLDA = 1'b1;
        tick("ar_act");
        #2 RESET = 1'b1;
        #1;
        model_reset();
        chk("ar_out", obs_vec(), 16'h7800);
        #1 RESET = 1'b0; DREQ = 4'd0; HLDA = 1'b0;
        tick("ar_after");

        // synchronous master clear mid-transfer
        DREQ = 4'b0100;
        tick("mc_hreq");
        HLDA = 1'b1;
        tick("mc_act");
        MCLR = 1'b1;
        tick("mc_clr");
        chk("mc_out", 16'({HRQ, DACK, ACT_VLD}), 16'h1E);
        MCLR = 1'b0; HLDA = 1'b0; DREQ = 4'd0;
        tick("mc_idle");

        // random traffic with a mostly cooperative CPU
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
            if ($urandom_range(0, 7) == 0) MASK = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            if ($urandom_range(0, 7) == 0) BLK = 4'($urandom);
            if ($urandom_range(0, 15) == 0) ROT_PRI = ~ROT_PRI;
            CTRL_DIS  = ($urandom_range(0, 9) == 0);
            if (m_st == 1 || m_st == 2) HLDA = ($urandom_range(0, 11) != 0);
            else HLDA = ($urandom_range(0, 5) == 0);
            XFER_DONE = ($urandom_range(0, 2) == 0);
            EOP_IN    = ($urandom_range(0, 7) == 0);
            STAT_RD   = ($urandom_range(0, 7) == 0);
            MCLR      = ($urandom_range(0, 99) == 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
